// File: rtl/chip_sched_pkg.sv
// chip_sched_pkg -- shared types and default constants for the chip access
// scheduler: opcode and FSM state encodings, default parameter values and a
// small one-hot helper used for per-requester response strobes.
package chip_sched_pkg;

   localparam int          DEF_ADDR_W     = 8;
   localparam int          DEF_DATA_W     = 8;
   localparam int          DEF_STROBE_CYC = 4;
   localparam int          DEF_TIMEOUT    = 1024;
   localparam logic [7:0]  DEF_RES_ADDR   = 8'hFF;
   localparam int          NUM_REQ        = 2;

   typedef enum logic [1:0] {
      OP_READ    = 2'b00,
      OP_WRITE   = 2'b01,
      OP_INFER   = 2'b10,
      OP_ILLEGAL = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_HOLD   = 3'd3,
      S_START  = 3'd4,
      S_WAIT   = 3'd5,
      S_RESP   = 3'd6
   } state_t;

   // One-hot strobe for a two-requester index.
   function automatic logic [1:0] onehot2(input logic idx);
      onehot2 = 2'b01 << idx;
   endfunction

endpackage

// File: rtl/chip_sched_rr.sv
// chip_sched_rr -- two-requester round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   valid      : request valid per requester
//   accept     : the current winner was accepted this cycle
//   grant      : one-hot winner (zero when nobody is valid)
//   idx        : index of the winner
// The favoured requester moves to the one that was NOT just granted, so the
// last-granted requester always has lowest priority.
module chip_sched_rr
   import chip_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant,
   output logic       idx
);

   logic prio;  // requester that wins a tie

   always_comb begin
      idx   = prio;
      if (!valid[prio]) idx = ~prio;
      grant = '0;
      if (|valid) grant = onehot2(idx);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)      prio <= 1'b0;
      else if (accept) prio <= ~idx;
   end

endmodule

// File: rtl/chip_sched.sv
// chip_sched -- schedules host and power-control accesses onto a single
// accelerator chip interface (READ / WRITE / INFER), one at a time.
//   clk, rst_n                        : clock, synchronous active-low reset
//   req_valid_i/req_ready_o           : per-requester request handshake
//   req_op_i/req_addr_i/req_wdata_i   : per-requester opcode, address, data
//   rsp_valid_o/rsp_ready_i           : per-requester response handshake
//   rsp_data_o/rsp_err_o              : shared response data / error
//   chip_cs_o/chip_we_o/chip_start_o  : chip select, write enable, start
//   chip_addr_o/chip_wdata_o          : chip address / write data
//   chip_rdata_i/chip_done_i          : chip read data / inference done
//   busy_o                            : FSM not idle
module chip_sched
   import chip_sched_pkg::*;
#(
   parameter int                ADDR_W     = DEF_ADDR_W,
   parameter int                DATA_W     = DEF_DATA_W,
   parameter int                STROBE_CYC = DEF_STROBE_CYC,
   parameter int                TIMEOUT    = DEF_TIMEOUT,
   parameter logic [ADDR_W-1:0] RES_ADDR   = ADDR_W'(DEF_RES_ADDR)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 req_valid_i,
   output logic [1:0]                 req_ready_o,
   input  logic [1:0][1:0]            req_op_i,
   input  logic [1:0][ADDR_W-1:0]     req_addr_i,
   input  logic [1:0][DATA_W-1:0]     req_wdata_i,
   output logic [1:0]                 rsp_valid_o,
   input  logic [1:0]                 rsp_ready_i,
   output logic [DATA_W-1:0]          rsp_data_o,
   output logic                       rsp_err_o,
   output logic                       chip_cs_o,
   output logic                       chip_we_o,
   output logic                       chip_start_o,
   output logic [ADDR_W-1:0]          chip_addr_o,
   output logic [DATA_W-1:0]          chip_wdata_o,
   input  logic [DATA_W-1:0]          chip_rdata_i,
   input  logic                       chip_done_i,
   output logic                       busy_o
);

   // One counter serves both the strobe length and the WAIT timeout.
   localparam int CNT_MAX = (TIMEOUT > STROBE_CYC) ? TIMEOUT : STROBE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT - 1);

   state_t           state;
   op_t              op_q;
   logic             gnt_q;
   logic [CNT_W-1:0] cnt;

   logic [1:0] rr_grant;
   logic       rr_idx;
   logic       accept;
   op_t        op_in;

   // Ready is only offered in IDLE; gated by reset so nothing is accepted
   // (and no output is high) while reset is asserted.
   assign req_ready_o = (state == S_IDLE && rst_n) ? rr_grant : 2'b00;
   assign accept      = |(req_valid_i & req_ready_o);
   assign op_in       = op_t'(req_op_i[rr_idx]);
   assign busy_o      = (state != S_IDLE);

   chip_sched_rr u_rr (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (req_valid_i),
      .accept (accept),
      .grant  (rr_grant),
      .idx    (rr_idx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         op_q         <= OP_READ;
         gnt_q        <= 1'b0;
         cnt          <= '0;
         chip_cs_o    <= 1'b0;
         chip_we_o    <= 1'b0;
         chip_start_o <= 1'b0;
         chip_addr_o  <= '0;
         chip_wdata_o <= '0;
         rsp_valid_o  <= '0;
         rsp_data_o   <= '0;
         rsp_err_o    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  gnt_q      <= rr_idx;
                  op_q       <= op_in;
                  rsp_data_o <= '0;
                  rsp_err_o  <= 1'b0;
                  case (op_in)
                     OP_READ, OP_WRITE: begin
                        state        <= S_SETUP;
                        chip_addr_o  <= req_addr_i[rr_idx];
                        chip_wdata_o <= req_wdata_i[rr_idx];
                     end
                     OP_INFER: begin
                        state        <= S_START;
                        chip_start_o <= 1'b1;
                     end
                     default: begin
                        // Illegal opcode: answer with an error, never touch the chip.
                        state       <= S_RESP;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= onehot2(rr_idx);
                     end
                  endcase
               end
            end
            S_SETUP: begin
               state     <= S_STROBE;
               chip_cs_o <= 1'b1;
               chip_we_o <= (op_q == OP_WRITE);
               cnt       <= '0;
            end
            S_STROBE: begin
               if (cnt == STROBE_LAST) begin
                  state     <= S_HOLD;
                  chip_cs_o <= 1'b0;
                  chip_we_o <= 1'b0;
                  // READ and the INFER result read both capture here.
                  if (op_q != OP_WRITE) rsp_data_o <= chip_rdata_i;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_HOLD: begin
               state        <= S_RESP;
               rsp_valid_o  <= onehot2(gnt_q);
               chip_addr_o  <= '0;
               chip_wdata_o <= '0;
            end
            S_START: begin
               state        <= S_WAIT;
               chip_start_o <= 1'b0;
               cnt          <= '0;
            end
            S_WAIT: begin
               // done has priority over an expiring timeout.
               if (chip_done_i) begin
                  state        <= S_SETUP;
                  chip_addr_o  <= RES_ADDR;
                  chip_wdata_o <= '0;
               end else if (cnt == WAIT_LAST) begin
                  state       <= S_RESP;
                  rsp_err_o   <= 1'b1;
                  rsp_data_o  <= '0;
                  rsp_valid_o <= onehot2(gnt_q);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready_i[gnt_q]) begin
                  state       <= S_IDLE;
                  rsp_valid_o <= '0;
                  rsp_data_o  <= '0;
                  rsp_err_o   <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chip_sched.sv
module tb_chip_sched;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req_valid_i;
   logic [1:0]      req_ready_o;
   logic [1:0][1:0] req_op_i;
   logic [1:0][7:0] req_addr_i;
   logic [1:0][7:0] req_wdata_i;
   logic [1:0]      rsp_valid_o;
   logic [1:0]      rsp_ready_i;
   logic [7:0]      rsp_data_o;
   logic            rsp_err_o;
   logic            chip_cs_o, chip_we_o, chip_start_o;
   logic [7:0]      chip_addr_o, chip_wdata_o;
   logic [7:0]      chip_rdata_i;
   logic            chip_done_i;
   logic            busy_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   chip_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_op_i     (req_op_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_data_o   (rsp_data_o),
      .rsp_err_o    (rsp_err_o),
      .chip_cs_o    (chip_cs_o),
      .chip_we_o    (chip_we_o),
      .chip_start_o (chip_start_o),
      .chip_addr_o  (chip_addr_o),
      .chip_wdata_o (chip_wdata_o),
      .chip_rdata_i (chip_rdata_i),
      .chip_done_i  (chip_done_i),
      .busy_o       (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a single request at a negedge; returns at the negedge after the
   // accepting posedge (first cycle after acceptance).
   task automatic issue(input int idx, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
      req_valid_i[idx] = 1'b1;
      req_op_i[idx]    = op;
      req_addr_i[idx]  = a;
      req_wdata_i[idx] = d;
      #1;
      chk("req_ready", {30'd0, req_ready_o}, 32'(2'b01 << idx));
      @(negedge clk);
      req_valid_i[idx] = 1'b0;
   endtask

   task automatic ack(input int idx);
      rsp_ready_i[idx] = 1'b1;
      @(negedge clk);
      rsp_ready_i[idx] = 1'b0;
      chk("rsp_valid_after_ack", {30'd0, rsp_valid_o}, 32'd0);
   endtask

   // Bounded wait for a response; lat counts cycles since acceptance.
   task automatic wait_rsp(input int idx, output int lat);
      lat = 1;
      while (!rsp_valid_o[idx] && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int starts;
      int cs_cnt;
      logic seen;

      rst_n = 1'b0;
      req_valid_i = '0; req_op_i = '0; req_addr_i = '0; req_wdata_i = '0;
      rsp_ready_i = '0; chip_rdata_i = '0; chip_done_i = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_busy", busy_o, 0);
      chk("rst_cs", chip_cs_o, 0);
      chk("rst_start", chip_start_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_addr", chip_addr_o, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // WRITE req0 0x12 <- 0xA5
      issue(0, 2'b01, 8'h12, 8'hA5);
      cs_cnt = 0;
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) @(negedge clk);
         if (chip_cs_o) cs_cnt++;
         chk($sformatf("wr_cs_k%0d", k), chip_cs_o, (k >= 2 && k <= 5));
         chk($sformatf("wr_we_k%0d", k), chip_we_o, (k >= 2 && k <= 5));
         chk($sformatf("wr_rspv_k%0d", k), rsp_valid_o, (k == 7) ? 1 : 0);
         if (k <= 6) chk($sformatf("wr_addr_k%0d", k), chip_addr_o, 8'h12);
         if (k <= 6) chk($sformatf("wr_wdata_k%0d", k), chip_wdata_o, 8'hA5);
      end
      chk("wr_cs_count", cs_cnt, 4);
      chk("wr_err", rsp_err_o, 0);
      chk("wr_data", rsp_data_o, 0);
      ack(0);
      chk("wr_idle_addr", chip_addr_o, 0);
      chk("wr_idle_busy", busy_o, 0);

      // READ req1 0x34; rdata valid only on the last strobe cycle
      chip_rdata_i = 8'hEE;
      issue(1, 2'b00, 8'h34, 8'h00);
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) @(negedge clk);
         chk($sformatf("rd_we_k%0d", k), chip_we_o, 0);
         chk($sformatf("rd_rspv_k%0d", k), rsp_valid_o, (k == 7) ? 2 : 0);
         if (k <= 6) chk($sformatf("rd_addr_k%0d", k), chip_addr_o, 8'h34);
         if (k == 5) chip_rdata_i = 8'h5C;
         if (k == 6) chip_rdata_i = 8'h11;
      end
      chk("rd_data", rsp_data_o, 8'h5C);
      chk("rd_err", rsp_err_o, 0);
      ack(1);

      // INFER req0, done during the 11th WAIT cycle, result 0x07
      chip_rdata_i = 8'h07;
      issue(0, 2'b10, 8'h00, 8'h00);
      starts = 0;
      for (int k = 1; k <= 19; k++) begin
         if (k > 1) @(negedge clk);
         if (chip_start_o) starts++;
         if (k == 1)  chk("inf_start_k1", chip_start_o, 1);
         if (k == 12) chk("inf_cs_wait", chip_cs_o, 0);
         if (k == 13) chk("inf_addr_res", chip_addr_o, 8'hFF);
         if (k == 14) chk("inf_cs_strobe", chip_cs_o, 1);
         if (k == 14) chk("inf_we_strobe", chip_we_o, 0);
         chk($sformatf("inf_rspv_k%0d", k), rsp_valid_o, (k == 19) ? 1 : 0);
         chip_done_i = (k == 12);
      end
      chip_done_i = 1'b0;
      chk("inf_starts", starts, 1);
      chk("inf_data", rsp_data_o, 8'h07);
      chk("inf_err", rsp_err_o, 0);
      ack(0);

      // INFER req1, done never arrives -> timeout error
      issue(1, 2'b10, 8'h00, 8'h00);
      cs_cnt = 0;
      for (int k = 1; k <= 1026; k++) begin
         if (k > 1) @(negedge clk);
         if (chip_cs_o) cs_cnt++;
         if (k == 1025) chk("to_rspv_k1025", rsp_valid_o, 0);
      end
      chk("to_rspv", rsp_valid_o, 2);
      chk("to_err", rsp_err_o, 1);
      chk("to_data", rsp_data_o, 0);
      chk("to_no_cs", cs_cnt, 0);
      ack(1);

      // INFER req0, done on the final WAIT cycle -> done wins
      chip_rdata_i = 8'h3B;
      issue(0, 2'b10, 8'h00, 8'h00);
      for (int k = 1; k <= 1032; k++) begin
         if (k > 1) @(negedge clk);
         if (k == 1026) chk("tofin_addr", chip_addr_o, 8'hFF);
         if (k == 1026) chk("tofin_rspv_early", rsp_valid_o, 0);
         chip_done_i = (k == 1025);
      end
      chip_done_i = 1'b0;
      chk("tofin_rspv", rsp_valid_o, 1);
      chk("tofin_err", rsp_err_o, 0);
      chk("tofin_data", rsp_data_o, 8'h3B);
      ack(0);

      // Reset during STROBE of a WRITE
      issue(0, 2'b01, 8'h55, 8'h3C);
      @(negedge clk);
      chk("abort_cs_before", chip_cs_o, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_cs", chip_cs_o, 0);
      chk("abort_we", chip_we_o, 0);
      chk("abort_busy", busy_o, 0);
      chk("abort_addr", chip_addr_o, 0);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid_o != 2'b00 || chip_cs_o) seen = 1'b1;
      end
      chk("abort_no_rsp", seen, 0);

      // Both requesters valid: req0 READ, req1 ILLEGAL; grants 0,1,0,1
      chip_rdata_i = 8'h99;
      req_op_i[0] = 2'b00; req_addr_i[0] = 8'h40;
      req_op_i[1] = 2'b11; req_addr_i[1] = 8'h41;
      req_valid_i = 2'b11;
      for (int n = 0; n < 4; n++) begin
         #1;
         chk($sformatf("rr_ready_n%0d", n), req_ready_o, (n % 2 == 0) ? 1 : 2);
         @(negedge clk);
         if (n % 2 == 1) begin
            chk($sformatf("ill_rspv_n%0d", n), rsp_valid_o, 2);
            chk($sformatf("ill_err_n%0d", n), rsp_err_o, 1);
            chk($sformatf("ill_data_n%0d", n), rsp_data_o, 0);
            chk($sformatf("ill_cs_n%0d", n), chip_cs_o, 0);
            ack(1);
         end else begin
            wait_rsp(0, lat);
            chk($sformatf("rr_lat_n%0d", n), lat, 7);
            chk($sformatf("rr_data_n%0d", n), rsp_data_o, 8'h99);
            if (n == 0) begin
               chip_rdata_i = 8'h00;
               for (int s = 0; s < 5; s++) begin
                  @(negedge clk);
                  chk($sformatf("stall_v_s%0d", s), rsp_valid_o, 1);
                  chk($sformatf("stall_d_s%0d", s), rsp_data_o, 8'h99);
               end
               chip_rdata_i = 8'h99;
            end
            ack(0);
         end
      end
      req_valid_i = 2'b00;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
